// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ID-stage MIPS fields into an AluOp, holds operands in the ID/EX register,
// and presents forwarded A/B operands to the ALU. Also raises load-use stalls and inserts bubbles.
module alu_issue_stage #(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [5:0]      id_opcode,
   input  logic [5:0]      id_funct,
   input  logic [4:0]      id_shamt,
   input  logic [15:0]     id_imm,
   input  logic [4:0]      id_rs,
   input  logic [4:0]      id_rt,
   input  logic [4:0]      id_rd,
   input  logic [SIZE-1:0] id_rs_data,
   input  logic [SIZE-1:0] id_rt_data,
   input  logic            stall_in,
   input  logic            flush,
   input  logic            exmem_wr,
   input  logic [4:0]      exmem_rd,
   input  logic [SIZE-1:0] exmem_result,
   input  logic            memwb_wr,
   input  logic [4:0]      memwb_rd,
   input  logic [SIZE-1:0] memwb_result,
   output logic            load_use_stall,
   output logic            ex_valid,
   output logic [3:0]      alu_op,
   output logic [SIZE-1:0] alu_a,
   output logic [SIZE-1:0] alu_b,
   output logic            ex_wr_en,
   output logic [4:0]      ex_wr_addr,
   output logic            ex_is_load,
   output logic [SIZE-1:0] ex_store_data,
   output logic            ex_illegal
);

   localparam logic [3:0] OP_ADD = 4'b0000, OP_ADDU = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0100,
                          OP_OR  = 4'b0101, OP_XOR  = 4'b0110, OP_NOR = 4'b0111, OP_SLL = 4'b1000,
                          OP_SRL = 4'b1001, OP_SLT  = 4'b1010, OP_SRA = 4'b1100;

   logic            decLegal, decWr, decLoad, decAReg, decBReg, rtIsSource;
   logic [3:0]      decOp;
   logic [4:0]      decDest;
   logic [SIZE-1:0] decA, decB, immSext, immZext;
   logic            decWrEff;

   logic            aIsReg, bIsReg;
   logic [4:0]      aAddr, bAddr, rtAddr;
   logic [SIZE-1:0] aVal, bVal, rtVal;

   assign immSext = {{(SIZE-16){id_imm[15]}}, id_imm};
   assign immZext = {{(SIZE-16){1'b0}}, id_imm};

   // Decode: A defaults to rs, B to rt; shifts, lui and immediates replace them with non-register values.
   always_comb begin
      decLegal   = 1'b1;
      decWr      = 1'b1;
      decLoad    = 1'b0;
      decOp      = OP_ADD;
      decDest    = id_rt;
      decAReg    = 1'b1;
      decA       = id_rs_data;
      decBReg    = 1'b0;
      decB       = immSext;
      rtIsSource = 1'b0;
      case (id_opcode)
         6'h00: begin
            decDest    = id_rd;
            decBReg    = 1'b1;
            decB       = id_rt_data;
            rtIsSource = 1'b1;
            case (id_funct)
               6'h20:         decOp = OP_ADD;
               6'h21:         decOp = OP_ADDU;
               6'h22, 6'h23:  decOp = OP_SUB;
               6'h24:         decOp = OP_AND;
               6'h25:         decOp = OP_OR;
               6'h26:         decOp = OP_XOR;
               6'h27:         decOp = OP_NOR;
               6'h2A:         decOp = OP_SLT;
               6'h00, 6'h02, 6'h03: begin
                  decOp   = (id_funct == 6'h00) ? OP_SLL : (id_funct == 6'h02) ? OP_SRL : OP_SRA;
                  decAReg = 1'b0;
                  decA    = {{(SIZE-5){1'b0}}, id_shamt};
               end
               default: decLegal = 1'b0;
            endcase
         end
         6'h08: decOp = OP_ADD;
         6'h09: decOp = OP_ADDU;
         6'h0A: decOp = OP_SLT;
         6'h0C: begin decOp = OP_AND; decB = immZext; end
         6'h0D: begin decOp = OP_OR;  decB = immZext; end
         6'h0E: begin decOp = OP_XOR; decB = immZext; end
         6'h0F: begin
            decOp   = OP_SLL;
            decAReg = 1'b0;
            decA    = SIZE'(16);
            decB    = immZext;
         end
         6'h23: decLoad = 1'b1;
         6'h2B: begin decWr = 1'b0; rtIsSource = 1'b1; end
         6'h04, 6'h05: begin
            decOp      = OP_SUB;
            decWr      = 1'b0;
            decBReg    = 1'b1;
            decB       = id_rt_data;
            rtIsSource = 1'b1;
         end
         default: begin decLegal = 1'b0; decWr = 1'b0; end
      endcase
   end

   assign decWrEff = decWr & (decDest != 5'd0);

   assign load_use_stall = id_valid & ex_valid & ex_is_load & (ex_wr_addr != 5'd0) &
                           ((ex_wr_addr == id_rs) | ((ex_wr_addr == id_rt) & rtIsSource));

   // ID/EX register; flush beats stall, and a held illegal flag is dropped so it only pulses once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         alu_op     <= 4'b0000;
         ex_wr_en   <= 1'b0;
         ex_wr_addr <= 5'd0;
         ex_is_load <= 1'b0;
         ex_illegal <= 1'b0;
         aIsReg     <= 1'b0;
         bIsReg     <= 1'b0;
         aAddr      <= 5'd0;
         bAddr      <= 5'd0;
         rtAddr     <= 5'd0;
         aVal       <= '0;
         bVal       <= '0;
         rtVal      <= '0;
      end else if (stall_in && !flush) begin
         ex_illegal <= 1'b0;
      end else if (flush || load_use_stall || !id_valid || !decLegal) begin
         ex_valid   <= 1'b0;
         alu_op     <= 4'b0000;
         ex_wr_en   <= 1'b0;
         ex_wr_addr <= 5'd0;
         ex_is_load <= 1'b0;
         ex_illegal <= !flush && !load_use_stall && id_valid && !decLegal;
      end else begin
         ex_valid   <= 1'b1;
         alu_op     <= decOp;
         ex_wr_en   <= decWrEff;
         ex_wr_addr <= decWrEff ? decDest : 5'd0;
         ex_is_load <= decLoad;
         ex_illegal <= 1'b0;
         aIsReg     <= decAReg;
         bIsReg     <= decBReg;
         aAddr      <= id_rs;
         bAddr      <= id_rt;
         rtAddr     <= id_rt;
         aVal       <= decA;
         bVal       <= decB;
         rtVal      <= id_rt_data;
      end
   end

   function automatic logic [SIZE-1:0] forwardValue(
      input logic [4:0]      addr,
      input logic [SIZE-1:0] stored,
      input logic            exWr,
      input logic [4:0]      exRd,
      input logic [SIZE-1:0] exRes,
      input logic            wbWr,
      input logic [4:0]      wbRd,
      input logic [SIZE-1:0] wbRes
   );
      if (exWr && exRd != 5'd0 && exRd == addr)      return exRes;
      else if (wbWr && wbRd != 5'd0 && wbRd == addr) return wbRes;
      else                                           return stored;
   endfunction

   assign alu_a = aIsReg ? forwardValue(aAddr, aVal, exmem_wr, exmem_rd, exmem_result,
                                        memwb_wr, memwb_rd, memwb_result) : aVal;
   assign alu_b = bIsReg ? forwardValue(bAddr, bVal, exmem_wr, exmem_rd, exmem_result,
                                        memwb_wr, memwb_rd, memwb_result) : bVal;
   assign ex_store_data = forwardValue(rtAddr, rtVal, exmem_wr, exmem_rd, exmem_result,
                                       memwb_wr, memwb_rd, memwb_result);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected EX-stage contents are queued as each
// instruction is driven and compared one cycle later; comb outputs are checked in place.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
   logic [15:0] id_imm;
   logic [31:0] id_rs_data, id_rt_data;
   logic        stall_in, flush;
   logic        exmem_wr, memwb_wr;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        load_use_stall, ex_valid, ex_wr_en, ex_is_load, ex_illegal;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [4:0]  ex_wr_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic        valid;
      logic [3:0]  op;
      logic [31:0] a, b, store;
      logic        wr;
      logic [4:0]  addr;
      logic        load, ill, chkOps;
   } exp_t;

   exp_t expQ[$];

   alu_issue_stage #(.SIZE(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
      .id_shamt(id_shamt), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall_in(stall_in), .flush(flush),
      .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid), .alu_op(alu_op), .alu_a(alu_a),
      .alu_b(alu_b), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
      .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
      id_valid = 1'b1; id_opcode = op; id_funct = fn; id_shamt = sh; id_imm = imm;
      id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
   endtask

   task automatic expectIssue(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic wr, input logic [4:0] addr,
                              input logic load, input logic [31:0] store);
      exp_t e;
      e.tag = tag; e.valid = 1'b1; e.op = op; e.a = a; e.b = b; e.store = store;
      e.wr = wr; e.addr = addr; e.load = load; e.ill = 1'b0; e.chkOps = 1'b1;
      expQ.push_back(e);
   endtask

   task automatic expectBubble(input string tag, input logic ill);
      exp_t e;
      e.tag = tag; e.valid = 1'b0; e.op = 4'b0000; e.a = '0; e.b = '0; e.store = '0;
      e.wr = 1'b0; e.addr = 5'd0; e.load = 1'b0; e.ill = ill; e.chkOps = 1'b0;
      expQ.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = expQ.pop_front();
      chk({e.tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
      chk({e.tag, ".op"}, 32'(alu_op), 32'(e.op));
      chk({e.tag, ".wr_en"}, 32'(ex_wr_en), 32'(e.wr));
      chk({e.tag, ".wr_addr"}, 32'(ex_wr_addr), 32'(e.addr));
      chk({e.tag, ".is_load"}, 32'(ex_is_load), 32'(e.load));
      chk({e.tag, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
      if (e.chkOps) begin
         chk({e.tag, ".a"}, alu_a, e.a);
         chk({e.tag, ".b"}, alu_b, e.b);
         chk({e.tag, ".store"}, ex_store_data, e.store);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
      exmem_wr = 1'b0; exmem_rd = 5'd0; exmem_result = '0;
      memwb_wr = 1'b0; memwb_rd = 5'd0; memwb_result = '0;
      applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      id_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expectBubble("reset", 1'b0);
      checkOutput();
      chk("reset.alu_a", alu_a, 32'h0);
      chk("reset.alu_b", alu_b, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Decode coverage of the main instruction classes
      applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      expectIssue("add", 4'b0000, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 32'd7);
      stepClock();
      applyStimulus(6'h00, 6'h00, 5'd3, 16'h0, 5'd0, 5'd2, 5'd4, 32'h99, 32'h11);
      expectIssue("sll", 4'b1000, 32'd3, 32'h11, 1'b1, 5'd4, 1'b0, 32'h11);
      stepClock();
      applyStimulus(6'h0F, 6'h00, 5'd0, 16'h1234, 5'd0, 5'd5, 5'd0, 32'h77, 32'h66);
      expectIssue("lui", 4'b1000, 32'd16, 32'h00001234, 1'b1, 5'd5, 1'b0, 32'h66);
      stepClock();
      applyStimulus(6'h00, 6'h23, 5'd0, 16'h0, 5'd9, 5'd10, 5'd8, 32'd100, 32'd30);
      expectIssue("subu", 4'b0010, 32'd100, 32'd30, 1'b1, 5'd8, 1'b0, 32'd30);
      stepClock();
      applyStimulus(6'h08, 6'h00, 5'd0, 16'hFFFC, 5'd1, 5'd6, 5'd0, 32'h20, 32'h0);
      expectIssue("addi", 4'b0000, 32'h20, 32'hFFFFFFFC, 1'b1, 5'd6, 1'b0, 32'h0);
      stepClock();
      applyStimulus(6'h0C, 6'h00, 5'd0, 16'h8000, 5'd1, 5'd7, 5'd0, 32'h5A, 32'h0);
      expectIssue("andi", 4'b0100, 32'h5A, 32'h00008000, 1'b1, 5'd7, 1'b0, 32'h0);
      stepClock();
      applyStimulus(6'h0A, 6'h00, 5'd0, 16'hFFFF, 5'd1, 5'd7, 5'd0, 32'h5A, 32'h0);
      expectIssue("slti", 4'b1010, 32'h5A, 32'hFFFFFFFF, 1'b1, 5'd7, 1'b0, 32'h0);
      stepClock();
      applyStimulus(6'h2B, 6'h00, 5'd0, 16'h0008, 5'd1, 5'd2, 5'd0, 32'h40, 32'hDEAD);
      expectIssue("sw", 4'b0000, 32'h40, 32'h8, 1'b0, 5'd0, 1'b0, 32'hDEAD);
      stepClock();
      applyStimulus(6'h05, 6'h00, 5'd0, 16'h0010, 5'd3, 5'd4, 5'd0, 32'd9, 32'd9);
      expectIssue("bne", 4'b0010, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 32'd9);
      stepClock();
      applyStimulus(6'h08, 6'h00, 5'd0, 16'h0001, 5'd1, 5'd0, 5'd0, 32'h3, 32'h0);
      expectIssue("addi_r0", 4'b0000, 32'h3, 32'h1, 1'b0, 5'd0, 1'b0, 32'h0);
      stepClock();
      applyStimulus(6'h00, 6'h27, 5'd0, 16'h0, 5'd1, 5'd2, 5'd11, 32'hF0F0, 32'h0F0F);
      expectIssue("nor", 4'b0111, 32'hF0F0, 32'h0F0F, 1'b1, 5'd11, 1'b0, 32'h0F0F);
      stepClock();
      applyStimulus(6'h3F, 6'h00, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
      expectBubble("illegal", 1'b1);
      stepClock();
      id_valid = 1'b0;
      expectBubble("illegal_end", 1'b0);
      stepClock();

      // Load-use: rt that is only a destination must not stall; rs and sw's rt must
      applyStimulus(6'h23, 6'h00, 5'd0, 16'hFFFC, 5'd1, 5'd6, 5'd0, 32'h100, 32'h0);
      expectIssue("lw1", 4'b0000, 32'h100, 32'hFFFFFFFC, 1'b1, 5'd6, 1'b1, 32'h0);
      stepClock();
      applyStimulus(6'h0D, 6'h00, 5'd0, 16'h000F, 5'd1, 5'd6, 5'd0, 32'h3, 32'h0);
      #1 chk("lus_ori", 32'(load_use_stall), 32'd0);
      expectIssue("ori", 4'b0101, 32'h3, 32'hF, 1'b1, 5'd6, 1'b0, 32'h0);
      stepClock();
      applyStimulus(6'h23, 6'h00, 5'd0, 16'hFFFC, 5'd1, 5'd6, 5'd0, 32'h100, 32'h0);
      expectIssue("lw2", 4'b0000, 32'h100, 32'hFFFFFFFC, 1'b1, 5'd6, 1'b1, 32'h0);
      stepClock();
      applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 5'd6, 5'd6, 5'd7, 32'h50, 32'h50);
      #1 chk("lus_add", 32'(load_use_stall), 32'd1);
      expectBubble("lus_bubble", 1'b0);
      stepClock();
      chk("lus_after", 32'(load_use_stall), 32'd0);
      expectIssue("add_after_lw", 4'b0000, 32'h50, 32'h50, 1'b1, 5'd7, 1'b0, 32'h50);
      stepClock();
      applyStimulus(6'h23, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd6, 5'd0, 32'h200, 32'h0);
      expectIssue("lw3", 4'b0000, 32'h200, 32'h0, 1'b1, 5'd6, 1'b1, 32'h0);
      stepClock();
      applyStimulus(6'h2B, 6'h00, 5'd0, 16'h0000, 5'd1, 5'd6, 5'd0, 32'h200, 32'h77);
      #1 chk("lus_sw", 32'(load_use_stall), 32'd1);
      expectBubble("lus_sw_bubble", 1'b0);
      stepClock();

      // Forwarding priority on a held EX instruction
      applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2);
      expectIssue("add_fwd", 4'b0000, 32'd1, 32'd2, 1'b1, 5'd9, 1'b0, 32'd2);
      stepClock();
      id_valid = 1'b0;
      exmem_wr = 1'b1; exmem_rd = 5'd2; exmem_result = 32'hAA;
      memwb_wr = 1'b1; memwb_rd = 5'd2; memwb_result = 32'hBB;
      #1;
      chk("fwd_exmem.b", alu_b, 32'hAA);
      chk("fwd_exmem.a", alu_a, 32'd1);
      chk("fwd_exmem.store", ex_store_data, 32'hAA);
      exmem_wr = 1'b0;
      #1 chk("fwd_memwb.b", alu_b, 32'hBB);
      memwb_rd = 5'd1;
      #1;
      chk("fwd_memwb.a", alu_a, 32'hBB);
      chk("fwd_memwb.b_none", alu_b, 32'd2);
      exmem_wr = 1'b1; exmem_rd = 5'd0; memwb_wr = 1'b0;
      #1 chk("fwd_rd0.b", alu_b, 32'd2);

      // Stall holds EX contents while forwarding keeps tracking; flush beats stall
      applyStimulus(6'h00, 6'h22, 5'd0, 16'h0, 5'd4, 5'd5, 5'd12, 32'd4, 32'd5);
      stall_in = 1'b1;
      exmem_wr = 1'b1; exmem_rd = 5'd1; exmem_result = 32'hCC;
      repeat (3) begin
         expectIssue("stall_hold", 4'b0000, 32'hCC, 32'd2, 1'b1, 5'd9, 1'b0, 32'd2);
         stepClock();
      end
      exmem_rd = 5'd2; exmem_result = 32'hDD;
      expectIssue("stall_refwd", 4'b0000, 32'd1, 32'hDD, 1'b1, 5'd9, 1'b0, 32'hDD);
      stepClock();
      flush = 1'b1;
      expectBubble("stall_flush", 1'b0);
      stepClock();
      stall_in = 1'b0; flush = 1'b0; exmem_wr = 1'b0;

      // Asynchronous reset in the middle of a cycle
      applyStimulus(6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      expectIssue("add_pre_reset", 4'b0000, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 32'd7);
      stepClock();
      #2 rst_n = 1'b0;
      #1;
      expectBubble("async_reset", 1'b0);
      checkOutput();
      chk("async_reset.alu_a", alu_a, 32'h0);
      chk("async_reset.alu_b", alu_b, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      id_valid = 1'b0;
      @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
